pe_row_sequencer: RTL and testbench
===================================

PE_ROW_SEQUENCER -- requirements
Module: pe_row_sequencer

Interface
REQ-001 Parameters: MAX_W = 16, max image-row length; MAX_S = 4, max filter-row length.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cfg_start  in  1  one-cycle pulse; begins a run; ignored while busy=1.
REQ-005 cfg_img_len  in  5  W, image-row length, sampled on accepted cfg_start.
REQ-006 cfg_flt_len  in  3  S, filter length, sampled on accepted cfg_start.
REQ-007 busy  out  1  high from accepted cfg_start until the final output handshake.
REQ-008 err_cfg  out  1  one-cycle pulse on a rejected configuration.
REQ-009 wgt_valid / wgt_ready / wgt_data  in / out / in  1/1/16  weight load stream.
REQ-010 img_valid / img_ready / img_data  in / out / in  1/1/16  image load stream.
REQ-011 pe_image_val, pe_weight_val  out  16 each  PE operands.
REQ-012 pe_image_en, pe_weight_en  out  1 each  PE MAC enables.
REQ-013 pe_psum_in  out  32  partial sum to the PE.
REQ-014 pe_psum_out  in  32  registered PE result; one-cycle PE latency.
REQ-015 out_valid / out_ready / out_data / out_last  out / in / out / out  1/1/32/1  result stream.

Function
REQ-016 FSM states: IDLE, LOAD_W, LOAD_I, MAC, DRAIN, OUTPUT.
REQ-017 IDLE + cfg_start with 1<=S<=MAX_S, 1<=W<=MAX_W, S<=W -> latch W and S, go to LOAD_W, busy=1.
REQ-018 IDLE + cfg_start with any other W/S -> err_cfg=1 next cycle, stay IDLE, busy=0.
REQ-019 LOAD_W: wgt_ready=1; each wgt_valid&&wgt_ready stores word k into wbuf[k]; after S words, go to LOAD_I.
REQ-020 LOAD_I: img_ready=1; each img_valid&&img_ready stores word into ibuf[k]; after W words, go to MAC with e=0, s=0.
REQ-021 wgt_ready and img_ready are 0 in every other state.
REQ-022 MAC, tap s of window e: pe_image_val=ibuf[e+s], pe_weight_val=wbuf[s], both enables=1.
REQ-023 MAC: pe_psum_in = 0 when s=0, else pe_psum_out; one tap per cycle; after s=S-1, go to DRAIN.
REQ-024 DRAIN (1 cycle): enables=0; out_data <= pe_psum_out; out_valid <= 1; out_last <= (e == W-S); go to OUTPUT.
REQ-025 OUTPUT: out_data and out_last are held stable while out_valid=1 and out_ready=0.
REQ-026 OUTPUT + out_ready: out_valid <= 0 at that edge; go to MAC with e+1, s=0 if e<W-S, else IDLE with busy=0.
REQ-027 Outside MAC: all pe_* outputs are 0, so the PE forwards 0.
REQ-028 Arithmetic is unsigned: 16x16 products, 32-bit accumulation, modulo 2^32, no saturation.
REQ-029 Windows: E = W-S+1; per-window latency = S MAC cycles + 1 DRAIN cycle + handshake wait.
REQ-030 Exactly E results per run; out_last=1 only on the final result.
REQ-031 cfg_start in non-IDLE states has no effect and raises no err_cfg.
REQ-032 Load streams tolerate valid gaps; the FSM waits in LOAD_W/LOAD_I indefinitely.

Reset
REQ-033 rst=1 at any edge, including mid-load, mid-MAC or mid-output: state=IDLE; busy, err_cfg, out_valid, out_last, wgt_ready, img_ready, pe_image_en, pe_weight_en = 0; out_data, pe_psum_in, pe_image_val, pe_weight_val = 0; counters = 0.
REQ-034 Buffer contents are not reset; a run never reads a buffer entry before writing it.
REQ-035 The first cfg_start after rst deasserts is accepted normally.

Verification
REQ-036 W=4, S=2, weights {1,2}, image {1,2,3,4}, out_ready=1 -> out_data 5, 8, 11; out_last only on 11; busy falls after the third handshake.
REQ-037 W=3, S=3, weights {2,2,2}, image {1,2,3} -> single output 12 with out_last=1; MAC asserted exactly 3 consecutive cycles.
REQ-038 Config W=2, S=3, then S=0, then S=5 -> err_cfg pulse each time, busy stays 0, no ready asserted.
REQ-039 W=4, S=4, all weights and image words = 0xFFFF -> out_data = 0xFFF80004 (mod 2^32 wrap).
REQ-040 W=4, S=2 run with out_ready held 0 for 5 cycles on the first result -> out_valid/out_data(5) stable, no MAC activity, then results continue in order.
REQ-041 rst asserted during the second MAC cycle -> all outputs at reset values next cycle; a new run with the REQ-036 stimulus then reproduces 5, 8, 11.

Source files
------------

// File: rtl/pe_row_sequencer.sv
// Row-stationary sequencer for one processing element: loads a filter row and an
// image row, then sweeps the filter across the image and streams one sum per window.
module pe_row_sequencer #(
  parameter int MAX_W = 16,
  parameter int MAX_S = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [4:0]  cfg_img_len,
  input  logic [2:0]  cfg_flt_len,
  output logic        busy,
  output logic        err_cfg,
  input  logic        wgt_valid,
  output logic        wgt_ready,
  input  logic [15:0] wgt_data,
  input  logic        img_valid,
  output logic        img_ready,
  input  logic [15:0] img_data,
  output logic [15:0] pe_image_val,
  output logic [15:0] pe_weight_val,
  output logic        pe_image_en,
  output logic        pe_weight_en,
  output logic [31:0] pe_psum_in,
  input  logic [31:0] pe_psum_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last
);

  localparam int IW = $clog2(MAX_W);
  localparam int SW = $clog2(MAX_S);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, MAC, DRAIN, OUTPUT} state_t;

  state_t        state;
  logic [4:0]    w_len;
  logic [2:0]    s_len;
  logic [4:0]    k;
  logic [IW-1:0] e;
  logic [SW-1:0] s;
  logic [IW-1:0] idx;
  logic [4:0]    last_e;
  logic          cfg_ok;
  logic          in_mac;

  logic [15:0] wbuf [MAX_S];
  logic [15:0] ibuf [MAX_W];

  assign cfg_ok = (cfg_flt_len != 3'd0) && (cfg_flt_len <= 3'(MAX_S)) &&
                  (cfg_img_len != 5'd0) && (cfg_img_len <= 5'(MAX_W)) &&
                  ({2'b00, cfg_flt_len} <= cfg_img_len);
  assign last_e = w_len - {2'b00, s_len};
  assign idx    = e + IW'(s);
  assign in_mac = (state == MAC);

  assign wgt_ready     = (state == LOAD_W);
  assign img_ready     = (state == LOAD_I);
  assign pe_image_en   = in_mac;
  assign pe_weight_en  = in_mac;
  assign pe_image_val  = in_mac ? ibuf[idx] : 16'd0;
  assign pe_weight_val = in_mac ? wbuf[s] : 16'd0;
  // First tap of each window starts from zero; later taps chain the PE's registered sum.
  assign pe_psum_in    = (in_mac && s != '0) ? pe_psum_out : 32'd0;

  // Buffers hold no reset: every entry a run reads is written earlier in that run.
  always_ff @(posedge clk) begin
    if (state == LOAD_W && wgt_valid) wbuf[k[SW-1:0]] <= wgt_data;
    if (state == LOAD_I && img_valid) ibuf[k[IW-1:0]] <= img_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w_len     <= '0;
      s_len     <= '0;
      k         <= '0;
      e         <= '0;
      s         <= '0;
      busy      <= 1'b0;
      err_cfg   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      err_cfg <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_ok) begin
              w_len <= cfg_img_len;
              s_len <= cfg_flt_len;
              k     <= '0;
              busy  <= 1'b1;
              state <= LOAD_W;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        LOAD_W: begin
          if (wgt_valid) begin
            if (k == {2'b00, s_len} - 5'd1) begin
              k     <= '0;
              state <= LOAD_I;
            end else begin
              k <= k + 5'd1;
            end
          end
        end
        LOAD_I: begin
          if (img_valid) begin
            if (k == w_len - 5'd1) begin
              k     <= '0;
              e     <= '0;
              s     <= '0;
              state <= MAC;
            end else begin
              k <= k + 5'd1;
            end
          end
        end
        MAC: begin
          if (3'(s) == s_len - 3'd1) begin
            s     <= '0;
            state <= DRAIN;
          end else begin
            s <= s + SW'(1);
          end
        end
        DRAIN: begin
          out_data  <= pe_psum_out;
          out_valid <= 1'b1;
          out_last  <= ({1'b0, e} == last_e);
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              busy  <= 1'b0;
              e     <= '0;
              state <= IDLE;
            end else begin
              e     <= e + IW'(1);
              state <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Bench for pe_row_sequencer: a behavioural PE closes the psum loop and a
// scoreboard queue checks every result handshake against hand-computed sums.
module tb_pe_row_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [4:0]  cfg_img_len = '0;
  logic [2:0]  cfg_flt_len = '0;
  logic        busy, err_cfg;
  logic        wgt_valid = 1'b0, wgt_ready;
  logic [15:0] wgt_data = '0;
  logic        img_valid = 1'b0, img_ready;
  logic [15:0] img_data = '0;
  logic [15:0] pe_image_val, pe_weight_val;
  logic        pe_image_en, pe_weight_en;
  logic [31:0] pe_psum_in, pe_psum_out;
  logic        out_valid, out_ready = 1'b1, out_last;
  logic [31:0] out_data;

  pe_row_sequencer #(.MAX_W(16), .MAX_S(4)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_img_len(cfg_img_len),
    .cfg_flt_len(cfg_flt_len), .busy(busy), .err_cfg(err_cfg),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
    .img_valid(img_valid), .img_ready(img_ready), .img_data(img_data),
    .pe_image_val(pe_image_val), .pe_weight_val(pe_weight_val),
    .pe_image_en(pe_image_en), .pe_weight_en(pe_weight_en),
    .pe_psum_in(pe_psum_in), .pe_psum_out(pe_psum_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Behavioural PE: registered multiply-accumulate with one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) pe_psum_out <= '0;
    else     pe_psum_out <= pe_psum_in +
                 ((pe_image_en && pe_weight_en) ? 32'(pe_image_val) * 32'(pe_weight_val) : 32'd0);
  end

  typedef struct { logic [31:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  int cyc = 0;
  int mac_cnt = 0;
  int mac_first = -1;
  int mac_last = -1;
  logic [15:0] wv [16];
  logic [15:0] iv [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: compares each accepted result with the oldest expectation.
  always @(negedge clk) begin
    cyc++;
    if (pe_image_en) begin
      mac_cnt++;
      if (mac_first < 0) mac_first = cyc;
      mac_last = cyc;
    end
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        timeout("unexpected_result");
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        $display("OUT data=%08h last=%0b expected=%08h/%0b", out_data, out_last, x.data, x.last);
        check("out_data", out_data, x.data);
        check("out_last", 32'(out_last), 32'(x.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    exp_t x;
    x.data = d;
    x.last = l;
    exp_q.push_back(x);
  endtask

  task automatic start(input logic [4:0] w, input logic [2:0] s);
    cfg_img_len = w;
    cfg_flt_len = s;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_stream(input bit is_img, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      int b;
      b = 0;
      if (is_img) begin img_valid = 1'b1; img_data = iv[i]; end
      else        begin wgt_valid = 1'b1; wgt_data = wv[i]; end
      while (!(is_img ? img_ready : wgt_ready) && b < 50) begin tick(); b++; end
      if (b >= 50) timeout("load_ready");
      tick();
      img_valid = 1'b0;
      wgt_valid = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int b;
    b = 0;
    while (busy && b < 500) begin tick(); b++; end
    if (busy) timeout(name);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err_cfg"}, 32'(err_cfg), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_wgt_ready"}, 32'(wgt_ready), 32'd0);
    check({tag, "_img_ready"}, 32'(img_ready), 32'd0);
    check({tag, "_pe_en"}, {30'd0, pe_image_en, pe_weight_en}, 32'd0);
    check({tag, "_pe_psum_in"}, pe_psum_in, 32'd0);
    check({tag, "_pe_vals"}, {pe_image_val, pe_weight_val}, 32'd0);
  endtask

  task automatic run_basic(input string tag);
    wv[0] = 16'd1; wv[1] = 16'd2;
    iv[0] = 16'd1; iv[1] = 16'd2; iv[2] = 16'd3; iv[3] = 16'd4;
    push(32'd5, 1'b0); push(32'd8, 1'b0); push(32'd11, 1'b1);
    n_out = 0;
    out_ready = 1'b1;
    start(5'd4, 3'd2);
    send_stream(1'b0, 2, 1'b0);
    send_stream(1'b1, 4, 1'b0);
    wait_idle(tag);
    check({tag, "_count"}, 32'(n_out), 32'd3);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    check_idle_outputs("reset");

    // W=4 S=2 with a rejected mid-run start and gappy weight stream
    wv[0] = 16'd1; wv[1] = 16'd2;
    iv[0] = 16'd1; iv[1] = 16'd2; iv[2] = 16'd3; iv[3] = 16'd4;
    push(32'd5, 1'b0); push(32'd8, 1'b0); push(32'd11, 1'b1);
    n_out = 0;
    start(5'd4, 3'd2);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_wgt_ready", 32'(wgt_ready), 32'd1);
    cfg_flt_len = 3'd0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("busy_start_no_err", 32'(err_cfg), 32'd0);
    check("busy_start_still_busy", 32'(busy), 32'd1);
    send_stream(1'b0, 2, 1'b1);
    send_stream(1'b1, 4, 1'b1);
    wait_idle("run_4x2");
    check("run_4x2_count", 32'(n_out), 32'd3);

    // W=3 S=3: single window, three consecutive MAC cycles
    wv[0] = 16'd2; wv[1] = 16'd2; wv[2] = 16'd2;
    iv[0] = 16'd1; iv[1] = 16'd2; iv[2] = 16'd3;
    push(32'd12, 1'b1);
    mac_cnt = 0; mac_first = -1; mac_last = -1;
    start(5'd3, 3'd3);
    send_stream(1'b0, 3, 1'b0);
    send_stream(1'b1, 3, 1'b0);
    wait_idle("run_3x3");
    check("run_3x3_mac_cycles", 32'(mac_cnt), 32'd3);
    check("run_3x3_mac_span", 32'(mac_last - mac_first), 32'd2);

    // Rejected configurations
    begin
      logic [4:0] bw [5];
      logic [2:0] bs [5];
      bw[0] = 5'd2;  bs[0] = 3'd3;
      bw[1] = 5'd2;  bs[1] = 3'd0;
      bw[2] = 5'd2;  bs[2] = 3'd5;
      bw[3] = 5'd0;  bs[3] = 3'd1;
      bw[4] = 5'd17; bs[4] = 3'd2;
      for (int i = 0; i < 5; i++) begin
        start(bw[i], bs[i]);
        $display("CFG w=%0d s=%0d err_cfg=%0b busy=%0b", bw[i], bs[i], err_cfg, busy);
        check("bad_cfg_err", 32'(err_cfg), 32'd1);
        check("bad_cfg_busy", 32'(busy), 32'd0);
        check("bad_cfg_ready", {30'd0, wgt_ready, img_ready}, 32'd0);
        tick();
        check("bad_cfg_err_pulse", 32'(err_cfg), 32'd0);
      end
    end

    // W=4 S=4 all ones: 4 * 0xFFFF^2 wraps modulo 2^32
    for (int i = 0; i < 4; i++) begin wv[i] = 16'hFFFF; iv[i] = 16'hFFFF; end
    push(32'hFFF8_0004, 1'b1);
    start(5'd4, 3'd4);
    send_stream(1'b0, 4, 1'b0);
    send_stream(1'b1, 4, 1'b0);
    wait_idle("run_wrap");

    // Back-pressure on the first result
    wv[0] = 16'd1; wv[1] = 16'd2;
    iv[0] = 16'd1; iv[1] = 16'd2; iv[2] = 16'd3; iv[3] = 16'd4;
    push(32'd5, 1'b0); push(32'd8, 1'b0); push(32'd11, 1'b1);
    out_ready = 1'b0;
    start(5'd4, 3'd2);
    send_stream(1'b0, 2, 1'b0);
    send_stream(1'b1, 4, 1'b0);
    begin
      int b;
      b = 0;
      while (!out_valid && b < 50) begin tick(); b++; end
      if (!out_valid) timeout("stall_wait_valid");
    end
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", out_data, 32'd5);
      check("stall_no_mac", 32'(pe_image_en), 32'd0);
    end
    tick();
    out_ready = 1'b1;
    wait_idle("run_stall");

    // Reset during the second MAC cycle, then a clean rerun
    wv[0] = 16'd1; wv[1] = 16'd2;
    iv[0] = 16'd1; iv[1] = 16'd2; iv[2] = 16'd3; iv[3] = 16'd4;
    start(5'd4, 3'd2);
    send_stream(1'b0, 2, 1'b0);
    send_stream(1'b1, 4, 1'b0);
    begin
      int b;
      b = 0;
      while (!pe_image_en && b < 50) begin tick(); b++; end
      if (!pe_image_en) timeout("mid_mac_wait");
    end
    tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("mid_mac_reset");
    exp_q.delete();
    rst = 1'b0;
    tick();
    run_basic("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
